// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
//
// Parallel-in / serial-out serializer with a ready/valid load handshake.
// A WIDTH-bit word is accepted from the upstream producer. It is then emitted
// one bit per ser_en strobe on sout. Each word carries its own bit order,
// captured with it. A load accepted on the last-bit edge of the current word
// is the back-to-back case, and the bit stream then has no gap.
//
// Ports
//   clk         in   sole clock, rising edge active
//   clr         in   asynchronous, active-high reset
//   din         in   parallel word, sampled only on an accepted load
//   load_valid  in   upstream presents a word on din
//   load_ready  out  a word is accepted this cycle (combinational)
//   lsb_first   in   bit order captured with the word (1 = bit 0 first)
//   ser_en      in   advance strobe: consume the current bit at this edge
//   sout        out  current serial bit
//   sout_valid  out  sout carries a valid bit
//   last        out  sout is the final bit of the word
//   busy        out  a word is in flight (same as sout_valid)
// -----------------------------------------------------------------------------
module piso_stream #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             lsb_first,
   input  logic             ser_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             last,
   output logic             busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shreg;  // word in flight; the output end depends on mode
   logic [CNT_W-1:0] cnt;    // index of the bit currently on sout
   logic             mode;   // lsb_first latched with the word

   logic in_shift;
   logic is_last;
   logic accept;

   assign in_shift = (state == SHIFT);
   assign is_last  = in_shift && (cnt == CNT_LAST);

   // Ready in IDLE, and also on the edge that consumes the last bit. The
   // second case lets the next word follow with no idle cycle.
   assign load_ready = !in_shift || (is_last && ser_en);
   assign accept     = load_valid && load_ready;

   // All outputs decode registered state only, apart from load_ready. They
   // therefore collapse to their idle values as soon as clr forces the
   // registers, with no clock edge needed.
   assign sout       = in_shift && (mode ? shreg[0] : shreg[WIDTH-1]);
   assign sout_valid = in_shift;
   assign busy       = in_shift;
   assign last       = is_last;

   // NOTE: sequential state uses non-blocking assignments so that every
   // register updates from pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         mode  <= 1'b0;
      end else if (accept) begin
         // Covers both the IDLE load and the back-to-back reload on the last
         // bit. The word in flight is complete in either case.
         shreg <= din;
         mode  <= lsb_first;
         cnt   <= '0;
         state <= SHIFT;
      end else if (in_shift && ser_en) begin
         if (is_last) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
         end else begin
            // Move the next bit to the output end and zero fill behind it.
            shreg <= mode ? (shreg >> 1) : (shreg << 1);
            cnt   <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// -----------------------------------------------------------------------------
// tb_piso_stream
//
// Bench for piso_stream. It has one WIDTH=4 instance and one WIDTH=8
// instance. Only one instance is driven at a time; the other sees
// load_valid = 0 and stays idle. The reference model holds the remaining
// bits of the word in flight as a queue, front first. A word expands into
// that queue in its output order when a load is accepted, and each advance
// pops one bit.
// -----------------------------------------------------------------------------
module tb_piso_stream;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   // Common stimulus, routed to the selected instance.
   int         sel = 4;
   logic [7:0] din;
   logic       lv, ls, se;

   logic [3:0] din4;
   logic       lv4, ls4, se4, lr4, so4, sv4, la4, bz4;
   logic [7:0] din8;
   logic       lv8, ls8, se8, lr8, so8, sv8, la8, bz8;

   assign din4 = (sel == 4) ? din[3:0] : 4'h0;
   assign lv4  = (sel == 4) && lv;
   assign ls4  = (sel == 4) && ls;
   assign se4  = (sel == 4) && se;
   assign din8 = (sel == 8) ? din : 8'h00;
   assign lv8  = (sel == 8) && lv;
   assign ls8  = (sel == 8) && ls;
   assign se8  = (sel == 8) && se;

   piso_stream #(.WIDTH(4)) dut4 (
      .clk(clk), .clr(clr), .din(din4), .load_valid(lv4), .load_ready(lr4),
      .lsb_first(ls4), .ser_en(se4), .sout(so4), .sout_valid(sv4),
      .last(la4), .busy(bz4)
   );

   piso_stream #(.WIDTH(8)) dut8 (
      .clk(clk), .clr(clr), .din(din8), .load_valid(lv8), .load_ready(lr8),
      .lsb_first(ls8), .ser_en(se8), .sout(so8), .sout_valid(sv8),
      .last(la8), .busy(bz8)
   );

   logic o_lr, o_so, o_sv, o_la, o_bz;
   assign o_lr = (sel == 4) ? lr4 : lr8;
   assign o_so = (sel == 4) ? so4 : so8;
   assign o_sv = (sel == 4) ? sv4 : sv8;
   assign o_la = (sel == 4) ? la4 : la8;
   assign o_bz = (sel == 4) ? bz4 : bz8;

   int n_checks = 0;
   int n_fail   = 0;
   bit mq[$];       // model: remaining bits of the word in flight
   bit cap[$];      // observed sout on every valid cycle
   bit last_acc = 1'b0;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compares the captured stream (first bit = MSB) against a constant.
   task automatic check_cap(input string tag, input int n, input logic [31:0] v);
      logic [31:0] packed_bits = '0;
      foreach (cap[i]) packed_bits = {packed_bits[30:0], cap[i]};
      check_val({tag, ":len"}, 32'(cap.size()), 32'(n));
      check_val({tag, ":bits"}, packed_bits, v);
      cap.delete();
   endtask

   // One clock cycle. The caller has already set the inputs. Outputs are
   // checked at the falling edge, then the model takes the rising edge.
   task automatic cycle(input string tag);
      bit exp_ready;
      @(negedge clk);
      exp_ready = (mq.size() == 0) || (mq.size() == 1 && se);
      check({tag, ":valid"}, o_sv, mq.size() > 0);
      check({tag, ":busy"},  o_bz, mq.size() > 0);
      check({tag, ":sout"},  o_so, (mq.size() > 0) ? mq[0] : 1'b0);
      check({tag, ":last"},  o_la, mq.size() == 1);
      check({tag, ":ready"}, o_lr, exp_ready);
      if (o_sv === 1'b1) cap.push_back(o_so);
      last_acc = lv && exp_ready;
      if (last_acc) begin
         mq.delete();
         for (int i = 0; i < sel; i++) mq.push_back(ls ? din[i] : din[sel-1-i]);
      end else if (mq.size() > 0 && se) begin
         void'(mq.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_now(input string tag);
      check({tag, ":sout"},  o_so, 1'b0);
      check({tag, ":valid"}, o_sv, 1'b0);
      check({tag, ":last"},  o_la, 1'b0);
      check({tag, ":busy"},  o_bz, 1'b0);
      check({tag, ":ready"}, o_lr, 1'b1);
   endtask

   initial begin
      clr = 1'b1; din = '0; lv = 1'b0; ls = 1'b0; se = 1'b0;
      #2;
      sel = 8; #0 check_idle_now("rst8");
      sel = 4; #0 check_idle_now("rst4");
      @(posedge clk); #1;
      clr = 1'b0;

      // WIDTH=4, MSB first: 0101 -> 0,1,0,1
      lv = 1; din = 8'h05; ls = 0; se = 1; cycle("msb4_load");
      lv = 0;
      for (int i = 0; i < 5; i++) cycle("msb4");
      check_cap("msb4_stream", 4, 32'b0101);

      // WIDTH=4, LSB first: 1010 -> 0,1,0,1
      lv = 1; din = 8'h0A; ls = 1; cycle("lsb4_load");
      lv = 0; ls = 0;
      for (int i = 0; i < 5; i++) cycle("lsb4");
      check_cap("lsb4_stream", 4, 32'b0101);

      // Back-to-back: 1100 then 0011, second word taken on the last bit
      lv = 1; din = 8'h0C; cycle("b2b_load1");
      din = 8'h03;
      for (int i = 0; i < 4; i++) cycle("b2b_w1");
      lv = 0;
      for (int i = 0; i < 5; i++) cycle("b2b_w2");
      check_cap("b2b_stream", 8, 32'b11000011);

      // Stall: 1001, ser_en low for 3 cycles while the 2nd bit is shown
      lv = 1; din = 8'h09; cycle("stall_load");
      lv = 0;
      cycle("stall_b1");
      se = 0;
      for (int i = 0; i < 3; i++) cycle("stall_hold");
      se = 1;
      for (int i = 0; i < 4; i++) cycle("stall_run");
      check_cap("stall_stream", 7, 32'b1000001);

      // WIDTH=8 mid-word reset during bit 3 of A5
      sel = 8;
      lv = 1; din = 8'hA5; ls = 0; cycle("clr_load");
      lv = 0;
      cycle("clr_b1");
      cycle("clr_b2");
      #2 clr = 1'b1;
      #1 check_idle_now("clr_async");
      clr = 1'b0;
      mq.delete();
      check_cap("clr_pre", 2, 32'b10);
      cycle("clr_idle");
      check_cap("clr_no_tail", 0, 32'h0);
      lv = 1; din = 8'h3C; ls = 0; cycle("post_load");
      lv = 0;
      for (int i = 0; i < 9; i++) cycle("post");
      check_cap("post_stream", 8, 32'h3C);

      // Ignored load: FF offered mid-word with lsb_first toggling
      lv = 1; din = 8'hA5; ls = 0; cycle("ign_load");
      din = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         ls = ~ls;
         cycle("ign_w1");
      end
      check_cap("ign_first", 8, 32'hA5);
      lv = 0;
      for (int i = 0; i < 9; i++) cycle("ign_w2");
      check_cap("ign_second", 8, 32'hFF);

      // Random traffic against the model; the producer holds a refused word
      lv = 0; last_acc = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!lv || last_acc) begin
            lv  = ($urandom_range(0, 1) == 1);
            din = 8'($urandom);
            ls  = 1'($urandom_range(0, 1));
         end
         se = ($urandom_range(0, 3) != 0);
         cycle("rnd");
      end
      cap.delete();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serializer with a ready/valid load handshake, per-word selectable bit order and a serial-advance strobe. It takes a WIDTH-bit word from an upstream producer and emits it one bit per advance on a single serial line, with valid and last-bit flags for the downstream consumer. Loading back-to-back on the final bit gives a gap-free bit stream. It replaces fixed 4-bit shift/load shifters wherever the datapath needs a generic serial link front end.

## Interface
- WIDTH, 8, word width in bits; legal range WIDTH ≥ 2
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden
- clk  in  1  sole clock; rising edge active
- clr  in  1  reset; asynchronous, active-high
- din  in  WIDTH  parallel word; sampled only on an accepted load
- load_valid  in  1  upstream has a word on din
- load_ready  out  1  block accepts a word this cycle
- lsb_first  in  1  bit order, sampled with the word: 1 = bit 0 first, 0 = bit WIDTH-1 first
- ser_en  in  1  advance strobe: 1 = consume the current bit at this edge, 0 = hold
- sout  out  1  current serial bit
- sout_valid  out  1  sout carries a valid bit
- last  out  1  sout is the final bit of the word
- busy  out  1  a word is in flight (same as sout_valid)

## Operation
- States: IDLE, SHIFT. Registers: shreg[WIDTH], cnt[CNT_W], mode (latched lsb_first), state.
- Load is accepted at a rising edge when load_valid && load_ready. On that edge:
  - shreg <= din
  - mode <= lsb_first
  - cnt <= 0
  - state <= SHIFT
- IDLE:
  - load_ready = 1
  - sout = 0, sout_valid = 0, last = 0
- SHIFT:
  - sout = shreg[WIDTH-1] when mode = 0, shreg[0] when mode = 1
  - sout_valid = busy = 1
  - last = (cnt == WIDTH-1)
- Advance: an edge in SHIFT with ser_en = 1 consumes the current bit.
  - Not last: shreg shifts toward the output end, zero fills, cnt increments.
  - Last, and a load is accepted on the same edge: reload from din and stay in SHIFT.
  - Last, no load: state <= IDLE and shreg <= 0.
- load_ready = (state == IDLE) || (last && ser_en). This output is combinational from state, cnt and ser_en.
- Without a load acceptance, din and lsb_first have no effect. Changing either mid-word does not disturb the word in flight.
- load_valid asserted while load_ready = 0 is ignored, and the upstream must hold the word. A word is never dropped or duplicated.
- ser_en = 0 in SHIFT freezes shreg, cnt, sout, last and sout_valid.
- ser_en is ignored in IDLE.

## Timing
- clr asserted at any time takes effect immediately, without waiting for a clock edge:
  - state = IDLE, shreg = 0, cnt = 0, mode = 0
  - outputs: sout = 0, sout_valid = 0, last = 0, busy = 0, load_ready = 1
- No load is accepted while clr = 1. A word in flight is discarded and last is never raised for it.
- First normal edge after clr deasserts behaves as a normal IDLE edge.
- Load latency: a load accepted at edge N puts the first bit on sout, with sout_valid = 1, in the cycle after edge N.
- With ser_en tied to 1, a word occupies exactly WIDTH cycles. Each stall cycle (ser_en = 0) adds one cycle.
- Back-to-back: a load accepted on the last-bit edge puts the new word's first bit out in the very next cycle. sout_valid stays high continuously, with zero idle cycles between words.
- Without a back-to-back load, sout_valid falls on the cycle after the last-bit edge.

## Test plan
- WIDTH=4, lsb_first=0: load 4'b0101 with ser_en=1. sout must read 0,1,0,1 on the 4 cycles after the load, with last high only on the 4th and sout_valid low on the 5th.
- WIDTH=4, lsb_first=1: load 4'b1010. sout must read 0,1,0,1, and last must be high on the 4th bit.
- Back-to-back, WIDTH=4: hold load_valid with 4'b1100 and then 4'b0011. Required response:
  - 8 contiguous sout_valid cycles reading 1,1,0,0,0,0,1,1
  - load_ready high only in IDLE and on each last cycle
- Stall, WIDTH=4: load 4'b1001, then drop ser_en for 3 cycles after the 2nd bit. sout must hold 0 with sout_valid=1 through the stall, and the word must complete in 7 cycles total with last on the final bit only.
- Mid-word reset, WIDTH=8: load 8'hA5, then pulse clr between clock edges during bit 3. Required response:
  - sout, sout_valid and last go to 0 and load_ready goes to 1 before the next edge
  - a following load of 8'h3C (MSB first) emits 0,0,1,1,1,1,0,0
- Ignored load: during an 8'hA5 word, assert load_valid with 8'hFF and toggle lsb_first. The word must still read 1,0,1,0,0,1,0,1, and 8'hFF must be taken only on the last-bit edge.
